fitness_countdown_timer: RTL and testbench
==========================================

Name: fitness_countdown_timer

Overview:
- Sequential successor to the combinational workout-time calculator; takes its 8-bit minute result, runs it down as an MM:SS countdown with start/pause/stop control, and flags completion.
- Parametrised in time width and clock-to-second ratio.
- Optional interval mode alternates WORK/REST phases for a programmable number of rounds.
- Sits between the time-calculation logic and the display/alarm drivers.

Parameters:
- TIME_W, 8: width of load_min and min_out, in minutes.
- TICK_DIV, 50000000: clock cycles per one-second tick. Must be >= 2.
- ROUND_W, 4: width of the rounds count.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- load_min, input, TIME_W: work duration in minutes, normally the calculator result.
- rest_min, input, TIME_W: rest duration in minutes. Used only when interval=1.
- rounds, input, ROUND_W: number of work phases when interval=1. 0 is treated as 1.
- interval, input, 1: 1 = WORK/REST interval mode, 0 = single countdown.
- start, input, 1: level-sampled each cycle. Begins a run from IDLE or DONE.
- pause, input, 1: single-cycle pulse. Toggles RUN<->PAUSE.
- stop, input, 1: abort to IDLE.
- min_out, output, TIME_W: remaining minutes.
- sec_out, output, 6: remaining seconds, 0..59.
- round_out, output, ROUND_W: current round, 1-based; 0 in IDLE.
- phase_rest, output, 1: 1 while a REST phase is counting.
- running, output, 1: 1 in RUN.
- done, output, 1: one-cycle pulse when the final phase reaches 00:00.
- alarm, output, 1: held high in DONE.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Prescaler 0. Latched parameters 0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per cycle: stop > pause > start.
- stop in any state: next cycle IDLE, all outputs 0, prescaler 0.
- IDLE or DONE with start=1:
  - If load_min != 0: latch load_min, rest_min, interval, and max(rounds,1).
  - min_out=load_min, sec_out=0, round_out=1, phase_rest=0, prescaler=0, state=RUN, alarm=0.
  - If load_min == 0: start is ignored and the state is unchanged.
  - Inputs changing after the latch have no effect until the next start.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - At TICK_DIV-1 (tick): prescaler wraps to 0 and the time decrements by one second.
  - If sec_out>0: sec_out-1. Otherwise sec_out=59 and min_out-1.
  - The first decrement occurs exactly TICK_DIV cycles after entering RUN.
- Phase end, on the tick that makes the time 00:00:
  - Non-interval, or WORK phase of the final round: min/sec stay 0, state=DONE, done pulses for exactly that one cycle, alarm=1, running=0.
  - Interval WORK phase, not the final round, with latched rest_min != 0: the 00:00 value is not displayed. The same cycle loads rest_min:00 and sets phase_rest=1.
  - Interval WORK phase, not the final round, with latched rest_min == 0: skip REST. Load the next WORK phase directly (round_out+1, load_min:00).
  - Interval REST end: round_out+1, load_min:00, phase_rest=0.
  - The prescaler keeps free-running across phase changes; there is no extra delay cycle.
- pause in RUN: go to PAUSE. Prescaler and time are frozen and keep their values; running=0.
- pause in PAUSE: back to RUN, resuming the prescaler from its frozen value.
- pause in IDLE or DONE: ignored.
- start in RUN or PAUSE: ignored.
- Simultaneous pause and tick in RUN: the tick's decrement is applied, then the state goes to PAUSE.
- Simultaneous stop with tick or done: stop wins; done does not pulse.
- DONE: holds until start (restart) or stop (to IDLE).
- Arithmetic: all counters unsigned. There is no underflow path because the phase end is detected before decrement past 00:00. round_out never exceeds the latched round count.

Test Plan (TICK_DIV=4):
- Basic countdown: load_min=1, interval=0, start for 1 cycle.
  - At +4 cycles: 00:59. At +240 cycles: 00:00.
  - done is high for exactly 1 cycle; alarm and DONE are held.
- Pause/resume: load 2 min, pulse pause at cycle 10 (time 01:58, prescaler 2). Hold 50 cycles, then pulse pause again.
  - Time is unchanged throughout the pause.
  - The next decrement occurs 2 cycles after resume.
- Interval mode: load_min=1, rest_min=1, rounds=2, interval=1.
  - At cycle 240: phase_rest=1, 01:00, round 1.
  - At cycle 480: round 2, phase_rest=0.
  - At cycle 720: done, with a total of exactly 1 done pulse.
- Zero and skip cases:
  - start with load_min=0: remains IDLE, all outputs 0.
  - interval with rest_min=0, rounds=3: rounds advance every 240 cycles with no REST; done at cycle 720.
- Stop priority: assert stop and pause together on the final tick cycle.
  - Result: IDLE, no done pulse, outputs 0.
- Async reset mid-run: assert rst mid-cycle in RUN at 00:30.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, start re-runs correctly from the new load_min.

Source files
------------

// File: rtl/fitness_countdown_timer.sv
// MM:SS workout countdown with start/pause/stop control and an optional
// WORK/REST interval mode; counts one second every TICK_DIV clock cycles.
module fitness_countdown_timer #(
   parameter int TIME_W   = 8,
   parameter int TICK_DIV = 50000000,
   parameter int ROUND_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [TIME_W-1:0]  load_min,
   input  logic [TIME_W-1:0]  rest_min,
   input  logic [ROUND_W-1:0] rounds,
   input  logic               interval,
   input  logic               start,
   input  logic               pause,
   input  logic               stop,
   output logic [TIME_W-1:0]  min_out,
   output logic [5:0]         sec_out,
   output logic [ROUND_W-1:0] round_out,
   output logic               phase_rest,
   output logic               running,
   output logic               done,
   output logic               alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t               state;
   logic [PW-1:0]        presc;
   logic [TIME_W-1:0]    lat_load;
   logic [TIME_W-1:0]    lat_rest;
   logic                 lat_interval;
   logic [ROUND_W-1:0]   lat_rounds;

   logic tick;
   logic last_sec;
   logic final_phase;
   logic finishing;

   // Control inputs are plain levels sampled every cycle (no handshake):
   // stop beats pause beats start; pause acts as a toggle only in RUN/PAUSE.
   always_comb begin
      tick        = (presc == TICK_LAST);
      last_sec    = (min_out == '0) && (sec_out == 6'd1);
      final_phase = !lat_interval || (!phase_rest && (round_out == lat_rounds));
      finishing   = tick && last_sec && final_phase;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         presc        <= '0;
         lat_load     <= '0;
         lat_rest     <= '0;
         lat_interval <= 1'b0;
         lat_rounds   <= '0;
         min_out      <= '0;
         sec_out      <= '0;
         round_out    <= '0;
         phase_rest   <= 1'b0;
         running      <= 1'b0;
         done         <= 1'b0;
         alarm        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state      <= S_IDLE;
            presc      <= '0;
            min_out    <= '0;
            sec_out    <= '0;
            round_out  <= '0;
            phase_rest <= 1'b0;
            running    <= 1'b0;
            alarm      <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start && (load_min != '0)) begin
                     lat_load     <= load_min;
                     lat_rest     <= rest_min;
                     lat_interval <= interval;
                     lat_rounds   <= (rounds == '0) ? ROUND_W'(1) : rounds;
                     min_out      <= load_min;
                     sec_out      <= '0;
                     round_out    <= ROUND_W'(1);
                     phase_rest   <= 1'b0;
                     presc        <= '0;
                     running      <= 1'b1;
                     alarm        <= 1'b0;
                     state        <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (tick) begin
                     presc <= '0;
                     // 00:01 -> 00:00 ends the phase; the next phase loads in the same cycle.
                     if (last_sec) begin
                        if (final_phase) begin
                           min_out <= '0;
                           sec_out <= '0;
                           running <= 1'b0;
                           done    <= 1'b1;
                           alarm   <= 1'b1;
                           state   <= S_DONE;
                        end else if (!phase_rest && (lat_rest != '0)) begin
                           min_out    <= lat_rest;
                           sec_out    <= '0;
                           phase_rest <= 1'b1;
                        end else begin
                           round_out  <= round_out + ROUND_W'(1);
                           min_out    <= lat_load;
                           sec_out    <= '0;
                           phase_rest <= 1'b0;
                        end
                     end else if (sec_out != '0) begin
                        sec_out <= sec_out - 6'd1;
                     end else begin
                        sec_out <= 6'd59;
                        min_out <= min_out - TIME_W'(1);
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
                  if (pause && !finishing) begin
                     running <= 1'b0;
                     state   <= S_PAUSE;
                  end
               end
               S_PAUSE: begin
                  if (pause) begin
                     running <= 1'b1;
                     state   <= S_RUN;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fitness_countdown_timer.sv
// Bench for fitness_countdown_timer: directed scenarios plus randomized runs,
// every cycle compared against a phase-list/total-seconds reference model.
module tb_fitness_countdown_timer;

   localparam int TIME_W   = 8;
   localparam int TICK_DIV = 4;
   localparam int ROUND_W  = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [TIME_W-1:0]  load_min = '0;
   logic [TIME_W-1:0]  rest_min = '0;
   logic [ROUND_W-1:0] rounds = '0;
   logic               interval = 1'b0;
   logic               start = 1'b0;
   logic               pause = 1'b0;
   logic               stop = 1'b0;
   logic [TIME_W-1:0]  min_out;
   logic [5:0]         sec_out;
   logic [ROUND_W-1:0] round_out;
   logic               phase_rest;
   logic               running;
   logic               done;
   logic               alarm;

   fitness_countdown_timer #(
      .TIME_W(TIME_W), .TICK_DIV(TICK_DIV), .ROUND_W(ROUND_W)
   ) dut (
      .clk(clk), .rst(rst), .load_min(load_min), .rest_min(rest_min),
      .rounds(rounds), .interval(interval), .start(start), .pause(pause),
      .stop(stop), .min_out(min_out), .sec_out(sec_out), .round_out(round_out),
      .phase_rest(phase_rest), .running(running), .done(done), .alarm(alarm)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model: remaining phases as a list, current phase as total seconds
   typedef struct {
      int secs;
      bit rest;
      int rnd;
   } phase_t;

   phase_t      ph_q[$];
   int          m_state = M_IDLE;
   int          m_rem   = 0;
   int          m_rnd   = 0;
   bit          m_rest  = 1'b0;
   bit          m_done  = 1'b0;
   int          m_ec    = 0;

   logic [31:0] exp_q[$];
   int          n_checks  = 0;
   int          n_fail    = 0;
   int          done_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {10'd0, min_out, sec_out, round_out, phase_rest, running, done, alarm};
   endfunction

   function automatic logic [31:0] model_vec();
      logic [TIME_W-1:0]  mm;
      logic [5:0]         ss;
      logic [ROUND_W-1:0] rr;
      mm = TIME_W'(m_rem / 60);
      ss = 6'(m_rem % 60);
      rr = ROUND_W'(m_rnd);
      return {10'd0, mm, ss, rr, m_rest, (m_state == M_RUN), m_done, (m_state == M_DONE)};
   endfunction

   task automatic model_reset();
      ph_q.delete();
      m_state = M_IDLE; m_rem = 0; m_rnd = 0; m_rest = 1'b0; m_done = 1'b0; m_ec = 0;
   endtask

   task automatic next_phase();
      phase_t p;
      p = ph_q.pop_front();
      m_rem = p.secs; m_rest = p.rest; m_rnd = p.rnd;
   endtask

   task automatic model_step();
      int n;
      phase_t p;
      m_done = 1'b0;
      if (stop) begin
         model_reset();
      end else if (m_state == M_IDLE || m_state == M_DONE) begin
         if (start && load_min != 0) begin
            ph_q.delete();
            n = (!interval) ? 1 : ((rounds == 0) ? 1 : int'(rounds));
            for (int r = 1; r <= n; r++) begin
               p.secs = int'(load_min) * 60; p.rest = 1'b0; p.rnd = r;
               ph_q.push_back(p);
               if (interval && r < n && rest_min != 0) begin
                  p.secs = int'(rest_min) * 60; p.rest = 1'b1; p.rnd = r;
                  ph_q.push_back(p);
               end
            end
            next_phase();
            m_ec = 0;
            m_state = M_RUN;
         end
      end else if (m_state == M_RUN) begin
         m_ec++;
         if (m_ec == TICK_DIV) begin
            m_ec = 0;
            m_rem--;
            if (m_rem == 0) begin
               if (ph_q.size() == 0) begin
                  m_state = M_DONE;
                  m_done = 1'b1;
               end else begin
                  next_phase();
               end
            end
         end
         if (m_state == M_RUN && pause) m_state = M_PAUSE;
      end else begin
         if (pause) m_state = M_RUN;
      end
   endtask

   // driver: one clock, advance model, compare every output
   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      exp_q.push_back(model_vec());
      #1;
      check("outputs", dut_vec(), exp_q.pop_front());
      if (done) done_cnt++;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic go_idle();
      stop = 1'b1; cycle(); stop = 1'b0;
   endtask

   task automatic do_start(input int lm, input int rm, input int rn, input bit iv);
      load_min = TIME_W'(lm); rest_min = TIME_W'(rm); rounds = ROUND_W'(rn); interval = iv;
      start = 1'b1; cycle(); start = 1'b0;
   endtask

   function automatic logic [31:0] mmss();
      return {18'd0, min_out, sec_out};
   endfunction

   initial begin
      int cnt0;
      #3;
      check("reset_outputs", dut_vec(), 32'd0);
      run_cycles(2);
      rst = 1'b0;
      cycle();

      // basic countdown
      cnt0 = done_cnt;
      do_start(1, 0, 0, 1'b0);
      check("basic_load", mmss(), {18'd0, 8'd1, 6'd0});
      run_cycles(4);
      check("basic_first_tick", mmss(), {18'd0, 8'd0, 6'd59});
      run_cycles(236);
      check("basic_end_time", mmss(), 32'd0);
      check("basic_done", {31'd0, done}, 32'd1);
      run_cycles(3);
      check("basic_done_once", done_cnt - cnt0, 1);
      check("basic_alarm_held", {30'd0, alarm, running}, 32'd2);

      // pause / resume
      go_idle();
      do_start(2, 0, 0, 1'b0);
      run_cycles(9);
      pause = 1'b1; cycle(); pause = 1'b0;
      check("pause_time", mmss(), {18'd0, 8'd1, 6'd58});
      run_cycles(50);
      check("pause_frozen", {mmss(), running}, {17'd0, 8'd1, 6'd58, 1'b0});
      pause = 1'b1; cycle(); pause = 1'b0;
      check("resume_running", {31'd0, running}, 32'd1);
      cycle();
      check("resume_plus1", mmss(), {18'd0, 8'd1, 6'd58});
      cycle();
      check("resume_plus2", mmss(), {18'd0, 8'd1, 6'd57});

      // interval mode with REST
      go_idle();
      cnt0 = done_cnt;
      do_start(1, 1, 2, 1'b1);
      run_cycles(240);
      check("ival_rest", {mmss(), round_out, phase_rest}, {13'd0, 8'd1, 6'd0, 4'd1, 1'b1});
      run_cycles(240);
      check("ival_round2", {mmss(), round_out, phase_rest}, {13'd0, 8'd1, 6'd0, 4'd2, 1'b0});
      run_cycles(240);
      check("ival_done", {31'd0, done}, 32'd1);
      run_cycles(2);
      check("ival_done_once", done_cnt - cnt0, 1);

      // zero load ignored
      go_idle();
      do_start(0, 1, 2, 1'b1);
      run_cycles(3);
      check("zero_load_idle", dut_vec(), 32'd0);

      // interval with no rest: skip REST
      do_start(1, 0, 3, 1'b1);
      run_cycles(240);
      check("skip_round2", {round_out, phase_rest}, {4'd2, 1'b0});
      run_cycles(240);
      check("skip_round3", {round_out, phase_rest}, {4'd3, 1'b0});
      run_cycles(240);
      check("skip_done", {31'd0, done}, 32'd1);

      // stop + pause on the final tick
      go_idle();
      cnt0 = done_cnt;
      do_start(1, 0, 0, 1'b0);
      run_cycles(239);
      stop = 1'b1; pause = 1'b1; cycle(); stop = 1'b0; pause = 1'b0;
      check("stop_prio_outputs", dut_vec(), 32'd0);
      check("stop_prio_no_done", done_cnt - cnt0, 0);

      // async reset in the middle of a run
      do_start(1, 0, 0, 1'b0);
      run_cycles(120);
      check("pre_reset_time", mmss(), {18'd0, 8'd0, 6'd30});
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("async_reset_outputs", dut_vec(), 32'd0);
      cycle();
      rst = 1'b0;
      cycle();
      do_start(2, 0, 0, 1'b0);
      run_cycles(4);
      check("after_reset_run", mmss(), {18'd0, 8'd1, 6'd59});

      // randomized runs
      for (int run = 0; run < 12; run++) begin
         go_idle();
         do_start($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 2), $urandom_range(0, 1),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         for (int c = 0; c < 3000 && m_state != M_IDLE && m_state != M_DONE; c++) begin
            pause    = ($urandom_range(0, 59) == 0);
            stop     = ($urandom_range(0, 1499) == 0);
            start    = ($urandom_range(0, 99) == 0);
            load_min = TIME_W'($urandom_range(0, 3));
            rest_min = TIME_W'($urandom_range(0, 3));
            rounds   = ROUND_W'($urandom_range(0, 15));
            interval = 1'($urandom_range(0, 1));
            cycle();
         end
         pause = 1'b0; stop = 1'b0; start = 1'b0;
         run_cycles(2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
